// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle MIPS control sequencer
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [7:0] ALU_AND = 8'h00;
  localparam logic [7:0] ALU_OR  = 8'h01;
  localparam logic [7:0] ALU_ADD = 8'h02;
  localparam logic [7:0] ALU_SUB = 8'h06;
  localparam logic [7:0] ALU_SLT = 8'h07;

  // Only signed add/sub/addi trap on overflow; and/or/slt/lw ignore the flag.
  function automatic logic ovf_traps(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_ADDI) || ((op == OP_RTYPE) && ((fn == FN_ADD) || (fn == FN_SUB)));
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// rtl/mc_alu_decode.sv - {opcode, funct} to ALU operation lookup with legal-instruction flag
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [7:0] alucontrol_o,
  output logic       legal_o
);

  always_comb begin
    alucontrol_o = ALU_AND;
    legal_o      = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  alucontrol_o = ALU_ADD;
          FN_SUB:  alucontrol_o = ALU_SUB;
          FN_AND:  alucontrol_o = ALU_AND;
          FN_OR:   alucontrol_o = ALU_OR;
          FN_SLT:  alucontrol_o = ALU_SLT;
          default: legal_o      = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: alucontrol_o = ALU_ADD;
      OP_BEQ:                alucontrol_o = ALU_SUB;
      OP_J:                  legal_o      = 1'b1;
      default:               legal_o      = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS control FSM with memory handshakes, retire counter and sticky halt
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             overflow,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_en,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             pc_en,
  output logic             Mem2Reg,
  output logic             PCsrc,
  output logic             ALUsrc,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             Jump,
  output logic [7:0]       alucontrol,
  output logic             instr_done,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [7:0]       alu_code;
  logic             legal;
  logic             is_r, is_lw, is_sw, is_beq, is_addi, is_j;

  mc_alu_decode u_alu_decode (
    .opcode_i     (opcode),
    .funct_i      (funct),
    .alucontrol_o (alu_code),
    .legal_o      (legal)
  );

  // opcode/funct come straight from the instruction register, stable after FETCH
  assign is_r    = (opcode == OP_RTYPE);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_addi = (opcode == OP_ADDI);
  assign is_j    = (opcode == OP_J);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    ir_en      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_en      = 1'b0;
    Mem2Reg    = 1'b0;
    PCsrc      = 1'b0;
    ALUsrc     = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    Jump       = 1'b0;
    alucontrol = ALU_AND;
    instr_done = 1'b0;
    halted     = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_en   = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: state_d = legal ? ST_EXEC : ST_HALT;

      ST_EXEC: begin
        alucontrol = alu_code;
        if (is_r) begin
          RegDst  = 1'b1;
          state_d = ST_WB;
        end else if (is_addi) begin
          ALUsrc  = 1'b1;
          state_d = ST_WB;
        end else if (is_lw || is_sw) begin
          ALUsrc  = 1'b1;
          state_d = ST_MEM;
        end else if (is_beq) begin
          PCsrc      = zero;
          pc_en      = 1'b1;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else if (is_j) begin
          Jump       = 1'b1;
          pc_en      = 1'b1;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_HALT;
        end
      end

      // Address operands held so the data memory sees a stable address across stalls
      ST_MEM: begin
        ALUsrc     = 1'b1;
        alucontrol = ALU_ADD;
        dmem_req   = 1'b1;
        dmem_we    = is_sw;
        if (dmem_ready) begin
          if (is_sw) begin
            pc_en      = 1'b1;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        RegDst     = is_r;
        ALUsrc     = is_addi || is_lw;
        alucontrol = alu_code;
        Mem2Reg    = is_lw;
        if (overflow && ovf_traps(opcode, funct)) begin
          state_d = ST_HALT;
        end else begin
          RegWrite   = 1'b1;
          pc_en      = 1'b1;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
      end

      ST_HALT: halted = 1'b1;

      default: state_d = ST_IDLE;
    endcase
  end

  assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, instr_done};
  assign retired   = retired_q;

endmodule
